inv_shift_rows_serial: RTL and testbench



---
 rtl/inv_shift_rows_serial.sv | 103 ++++++++++
 tb/tb_inv_shift_rows_serial.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES InvShiftRows with a ping-pong pair of 16-byte banks.
// Input fills one bank while the other drains, giving one byte per clock each side.
module inv_shift_rows_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  bank_st_e   st_q [2];
  bank_st_e   st_d [2];
  logic [7:0] bank_q [2][16];
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic [1:0] full;
  logic       wr_en, rd_en;
  logic [1:0] rd_row, rd_col, src_col;
  logic [3:0] rd_addr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i] = (st_q[i] == StFull) || (st_q[i] == StDraining);
    end
  end

  assign in_ready  = ~full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign wr_en     = in_valid & in_ready;
  assign rd_en     = out_valid & out_ready;

  // Output byte (r, c) comes from stored column (c - r) mod 4; 2-bit subtract wraps for free.
  assign rd_row  = rd_cnt_q[1:0];
  assign rd_col  = rd_cnt_q[3:2];
  assign src_col = rd_col - rd_row;
  assign rd_addr = {src_col, rd_row};

  assign out_byte = out_valid ? bank_q[rd_bank_q][rd_addr] : 8'h00;
  assign out_last = out_valid & (rd_cnt_q == 4'd15);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
    end
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    // Write and read always target different banks, so both updates can apply together.
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (st_q[wr_bank_q] == StEmpty) st_d[wr_bank_q] = StFilling;
      if (wr_cnt_q == 4'd15) begin
        st_d[wr_bank_q] = StFull;
        wr_bank_d       = ~wr_bank_q;
      end
    end

    if (rd_en) begin
      rd_cnt_d        = rd_cnt_q + 4'd1;
      st_d[rd_bank_q] = StDraining;
      if (rd_cnt_q == 4'd15) begin
        st_d[rd_bank_q] = StEmpty;
        rd_bank_d       = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= StEmpty;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_cnt_q  <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= st_d[i];
      end
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Storage needs no reset; only the control state decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wr_bank_q][wr_cnt_q] <= in_byte;
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Self-checking bench for inv_shift_rows_serial against a row/column InvShiftRows model.
module tb_inv_shift_rows_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  logic [7:0] in_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         last_q [$];
  int         acc_cyc_q [$];
  int         out_cyc_q [$];
  int         stable_err;
  int         ready_low;
  bit         timed_out;

  always #5 clk = ~clk;

  inv_shift_rows_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last)
  );

  // Reference: view the block as a 4x4 column-major matrix and rotate each row right by r.
  function automatic void model_block(input logic [127:0] v);
    logic [7:0] st [4][4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = v[127 - 8*(4*c + r) -: 8];
    for (int n = 0; n < 16; n++) exp_q.push_back(st[n % 4][((n / 4) - (n % 4) + 4) % 4]);
  endfunction

  task automatic load_block(input logic [127:0] v);
    for (int n = 0; n < 16; n++) in_q.push_back(v[127 - 8*n -: 8]);
    model_block(v);
  endtask

  task automatic clear_all();
    in_q.delete(); exp_q.delete(); got_q.delete(); last_q.delete();
    acc_cyc_q.delete(); out_cyc_q.delete();
    stable_err = 0; ready_low = 0; timed_out = 0;
  endtask

  // Called at posedge+1; drives/monitors one cycle per iteration until n_out bytes seen.
  task automatic run_stream(input int vin_pct, input int rdy_pct, input int n_out,
                            input int budget);
    int         cyc = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_b = 8'h00;
    while (got_q.size() < n_out && cyc < budget) begin
      in_valid  = (in_q.size() > 0) && ($urandom_range(99) < vin_pct);
      in_byte   = in_valid ? in_q[0] : 8'($urandom);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (prev_stall && (!out_valid || out_byte !== prev_b)) stable_err++;
      if (!in_ready) ready_low++;
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        acc_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        last_q.push_back(out_last);
        out_cyc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_b     = out_byte;
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = (got_q.size() < n_out);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_timeout(input string name);
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", name, got_q.size(),
               exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_byte, out_last} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b byte=%h last=%b, required 1 0 00 0",
               in_ready, out_valid, out_byte, out_last);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    logic [127:0] e;
    clear_all();
    e = 128'hd42711aee0bf98f1b8b45de51e415230;
    load_block(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    run_stream(100, 100, 16, 200);
    check_timeout("fips");
    for (int n = 0; n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== e[127 - 8*n -: 8] || last_q[n] !== (n == 15)) begin
        bad++;
        $display("FAIL fips byte %0d: got %h last=%b, required %h last=%b", n, got_q[n],
                 last_q[n], e[127 - 8*n -: 8], n == 15);
      end
    end
    total++;
    if (out_cyc_q.size() != 16 || acc_cyc_q.size() != 16 || out_cyc_q[0] != acc_cyc_q[15] + 1)
    begin
      bad++;
      $display("FAIL fips_latency: got first out cycle %0d, required %0d",
               out_cyc_q.size() ? out_cyc_q[0] : -1,
               acc_cyc_q.size() == 16 ? acc_cyc_q[15] + 1 : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    clear_all();
    e = 128'h000d0a0704010e0b0805020f0c090603;
    load_block(128'h000102030405060708090a0b0c0d0e0f);
    load_block(128'h000102030405060708090a0b0c0d0e0f);
    run_stream(100, 100, 32, 200);
    check_timeout("b2b");
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== e[127 - 8*(i % 16) -: 8] || out_cyc_q[i] != 16 + i) begin
        bad++;
        $display("FAIL b2b byte %0d: got %h at cycle %0d, required %h at cycle %0d", i,
                 got_q[i], out_cyc_q[i], e[127 - 8*(i % 16) -: 8], 16 + i);
      end
    end
    total++;
    if (ready_low != 0) begin
      bad++;
      $display("FAIL b2b_in_ready: got %0d low cycles, required 0", ready_low);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    clear_all();
    for (int b = 0; b < 3; b++)
      load_block({$urandom, $urandom, $urandom, $urandom});
    out_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      in_byte  = in_q[0];
      if (in_ready) begin
        void'(in_q.pop_front());
        acc++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (acc != 32 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: got acc=%0d rdy=%b vld=%b, required acc=32 rdy=0 vld=1", acc,
               in_ready, out_valid);
    end
    run_stream(100, 100, 48, 400);
    check_timeout("bp");
    total++;
    if (acc_cyc_q.size() == 0 || out_cyc_q.size() < 16 || out_cyc_q[15] != 15 ||
        acc_cyc_q[0] != 16) begin
      bad++;
      $display("FAIL bp_ready_return: got first accept %0d, required 16",
               acc_cyc_q.size() ? acc_cyc_q[0] : -1);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp byte %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int b = 0; b < 100; b++)
      load_block({$urandom, $urandom, $urandom, $urandom});
    run_stream(70, 60, 1600, 20000);
    check_timeout("random");
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i % 16 == 15)) begin
        bad++;
        $display("FAIL random byte %0d: got %h last=%b, required %h last=%b", i, got_q[i],
                 last_q[i], exp_q[i], i % 16 == 15);
      end
    end
    total++;
    if (stable_err != 0) begin
      bad++;
      $display("FAIL random_stall_stability: got %0d violations, required 0", stable_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] e;
    clear_all();
    load_block({$urandom, $urandom, $urandom, $urandom});
    load_block({$urandom, $urandom, $urandom, $urandom});
    out_ready = 1'b0;
    for (int k = 0; k < 23; k++) begin
      in_valid = 1'b1;
      in_byte  = in_q[0];
      if (in_ready) void'(in_q.pop_front());
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, out_byte, out_last} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b byte=%h last=%b, required 1 0 00 0",
               in_ready, out_valid, out_byte, out_last);
    end
    rst_n = 1'b1;
    clear_all();
    e = 128'h101d1a1714111e1b1815121f1c191613;
    load_block(128'h101112131415161718191a1b1c1d1e1f);
    run_stream(100, 100, 16, 200);
    check_timeout("mid_reset");
    for (int n = 0; n < got_q.size(); n++) begin
      total++;
      if (got_q[n] !== e[127 - 8*n -: 8]) begin
        bad++;
        $display("FAIL mid_reset byte %0d: got %h, required %h", n, got_q[n],
                 e[127 - 8*n -: 8]);
      end
    end
  endtask

  task automatic test_row0();
    logic [127:0] v;
    logic [7:0]   e;
    clear_all();
    v = '0;
    for (int n = 0; n < 16; n += 4) v[127 - 8*n -: 8] = 8'haa;
    load_block(v);
    run_stream(100, 100, 16, 200);
    check_timeout("row0");
    for (int n = 0; n < got_q.size(); n++) begin
      e = (n % 4 == 0) ? 8'haa : 8'h00;
      total++;
      if (got_q[n] !== e) begin
        bad++;
        $display("FAIL row0 byte %0d: got %h, required %h", n, got_q[n], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_row0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
